// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with a return-address stack.
// Executes INC/DEC/LOAD/BRANCH/CALL/RET in one cycle.
// CALL on a full stack and RET on an empty stack are refused and raise a sticky error.
module pc_stack_unit #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          pcu_clk,
    input  logic                          pcu_rst_n,
    input  logic                          pcu_en,
    input  logic [2:0]                    pcu_op,
    input  logic [WIDTH-1:0]              pcu_in,
    input  logic                          pcu_rd_en,
    input  logic                          pcu_err_clr,
    output logic [WIDTH-1:0]              pcu_out,
    output logic                          pcu_full,
    output logic                          pcu_empty,
    output logic [$clog2(DEPTH+1)-1:0]    pcu_level,
    output logic                          pcu_err
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_INC    = 3'b001;
    localparam logic [2:0] OP_DEC    = 3'b010;
    localparam logic [2:0] OP_LOAD   = 3'b011;
    localparam logic [2:0] OP_BRANCH = 3'b100;
    localparam logic [2:0] OP_CALL   = 3'b101;
    localparam logic [2:0] OP_RET    = 3'b110;

    logic [WIDTH-1:0] r_pc;
    logic [LW-1:0]    r_level;
    logic             r_err;
    logic [WIDTH-1:0] r_stack [DEPTH];

    logic [WIDTH-1:0] w_pc_plus1;
    logic [WIDTH-1:0] w_pc_minus1;
    logic [WIDTH-1:0] w_pc_branch;
    logic [WIDTH-1:0] w_tos;
    logic [SW-1:0]    w_push_idx;
    logic [SW-1:0]    w_pop_idx;
    logic             w_full;
    logic             w_empty;

    logic [WIDTH-1:0] w_pc_nxt;
    logic [LW-1:0]    w_level_nxt;
    logic             w_push;
    logic             w_fault;
    logic             w_err_nxt;

    // Arithmetic candidates and stack status derived from registered state
    always_comb begin
        w_pc_plus1  = r_pc + WIDTH'(1);
        w_pc_minus1 = r_pc - WIDTH'(1);
        // pcu_in already spans WIDTH bits, so its sign extension is itself;
        // the sum simply wraps modulo 2^WIDTH.
        w_pc_branch = r_pc + pcu_in;
        w_full      = (r_level == LW'(DEPTH));
        w_empty     = (r_level == LW'(0));
        w_push_idx  = SW'(r_level);
        w_pop_idx   = SW'(r_level - LW'(1));
        w_tos       = r_stack[w_pop_idx];
    end

    // Next PC, level and push/fault decode for the operation in flight
    always_comb begin
        w_pc_nxt    = r_pc;
        w_level_nxt = r_level;
        w_push      = 1'b0;
        w_fault     = 1'b0;
        if (pcu_en) begin
            case (pcu_op)
                OP_INC:    w_pc_nxt = w_pc_plus1;
                OP_DEC:    w_pc_nxt = w_pc_minus1;
                OP_LOAD:   w_pc_nxt = pcu_in;
                OP_BRANCH: w_pc_nxt = w_pc_branch;
                OP_CALL: begin
                    if (w_full) begin
                        w_fault = 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_pc_nxt    = pcu_in;
                        w_level_nxt = r_level + LW'(1);
                    end
                end
                OP_RET: begin
                    if (w_empty) begin
                        w_fault = 1'b1;
                    end else begin
                        w_pc_nxt    = w_tos;
                        w_level_nxt = r_level - LW'(1);
                    end
                end
                default: begin
                    // HOLD and the reserved code leave everything unchanged
                    w_pc_nxt    = r_pc;
                    w_level_nxt = r_level;
                end
            endcase
        end
    end

    // Sticky error: a new fault wins over a simultaneous clear
    always_comb begin
        w_err_nxt = r_err;
        if (pcu_err_clr) begin
            w_err_nxt = 1'b0;
        end
        if (w_fault) begin
            w_err_nxt = 1'b1;
        end
    end

    // PC, stack level and error registers
    always_ff @(posedge pcu_clk or negedge pcu_rst_n) begin
        if (!pcu_rst_n) begin
            r_pc    <= RESET_VAL;
            r_level <= '0;
            r_err   <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_level <= w_level_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Stack storage; contents above the level are don't-care, so no reset
    always_ff @(posedge pcu_clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_plus1;
        end
    end

    // Output drive; rd_en gates only the visible PC
    always_comb begin
        pcu_out   = pcu_rd_en ? r_pc : '0;
        pcu_level = r_level;
        pcu_full  = w_full;
        pcu_empty = w_empty;
        pcu_err   = r_err;
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit (WIDTH=8, DEPTH=4, RESET_VAL=0).
// Stimulus pushes hand-computed expectations; a monitor pops and checks them.
module tb_pc_stack_unit;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH + 1);

    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] INC  = 3'b001;
    localparam logic [2:0] DEC  = 3'b010;
    localparam logic [2:0] LOAD = 3'b011;
    localparam logic [2:0] BRN  = 3'b100;
    localparam logic [2:0] CALL = 3'b101;
    localparam logic [2:0] RET  = 3'b110;
    localparam logic [2:0] RSV  = 3'b111;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [2:0]       op;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic             err_clr;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic [LW-1:0]    level;
    logic             err;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] out;
        logic [LW-1:0]    lvl;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    pc_stack_unit #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (8'h00)
    ) dut (
        .pcu_clk     (clk),
        .pcu_rst_n   (rst_n),
        .pcu_en      (en),
        .pcu_op      (op),
        .pcu_in      (din),
        .pcu_rd_en   (rd_en),
        .pcu_err_clr (err_clr),
        .pcu_out     (dout),
        .pcu_full    (full),
        .pcu_empty   (empty),
        .pcu_level   (level),
        .pcu_err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input string field, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h expected %0h", name, field, got, want);
        end
    endtask

    // Monitor: outputs are stable at the falling edge; check one expectation there
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, "out",   32'(dout),  32'(e.out));
            check(e.name, "level", 32'(level), 32'(e.lvl));
            check(e.name, "full",  32'(full),  32'(e.lvl == LW'(DEPTH)));
            check(e.name, "empty", 32'(empty), 32'(e.lvl == LW'(0)));
            check(e.name, "err",   32'(err),   32'(e.err));
        end
    end

    task automatic expect_state(input string name, input logic [WIDTH-1:0] eout,
                                input logic [LW-1:0] elvl, input logic eerr);
        exp_t e;
        e.name = name;
        e.out  = eout;
        e.lvl  = elvl;
        e.err  = eerr;
        exp_q.push_back(e);
    endtask

    // One clocked operation, then queue the state it must leave behind
    task automatic step(input string name, input logic s_en, input logic [2:0] s_op,
                        input logic [WIDTH-1:0] s_in, input logic s_rd, input logic s_clr,
                        input logic [WIDTH-1:0] eout, input logic [LW-1:0] elvl, input logic eerr);
        @(negedge clk);
        #1;
        rst_n   = 1'b1;
        en      = s_en;
        op      = s_op;
        din     = s_in;
        rd_en   = s_rd;
        err_clr = s_clr;
        @(posedge clk);
        #1;
        expect_state(name, eout, elvl, eerr);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        op      = HOLD;
        din     = '0;
        rd_en   = 1'b1;
        err_clr = 1'b0;
        #2;
        expect_state("reset", 8'h00, 3'd0, 1'b0);

        step("inc1",     1, INC,  8'h00, 1, 0, 8'h01, 3'd0, 0);
        step("inc2",     1, INC,  8'h00, 1, 0, 8'h02, 3'd0, 0);
        step("inc3",     1, INC,  8'h00, 1, 0, 8'h03, 3'd0, 0);
        step("rd_off",   1, HOLD, 8'h00, 0, 0, 8'h00, 3'd0, 0);
        step("rd_on",    1, HOLD, 8'h00, 1, 0, 8'h03, 3'd0, 0);
        step("load0",    1, LOAD, 8'h00, 1, 0, 8'h00, 3'd0, 0);
        step("dec_wrap", 1, DEC,  8'h00, 1, 0, 8'hFF, 3'd0, 0);
        step("inc_wrap", 1, INC,  8'h00, 1, 0, 8'h00, 3'd0, 0);

        step("load10",   1, LOAD, 8'h10, 1, 0, 8'h10, 3'd0, 0);
        step("br_neg",   1, BRN,  8'hF8, 1, 0, 8'h08, 3'd0, 0);
        step("loadFE",   1, LOAD, 8'hFE, 1, 0, 8'hFE, 3'd0, 0);
        step("br_wrap",  1, BRN,  8'h05, 1, 0, 8'h03, 3'd0, 0);

        step("load20",   1, LOAD, 8'h20, 1, 0, 8'h20, 3'd0, 0);
        step("call40",   1, CALL, 8'h40, 1, 0, 8'h40, 3'd1, 0);
        step("call50",   1, CALL, 8'h50, 1, 0, 8'h50, 3'd2, 0);
        step("call60",   1, CALL, 8'h60, 1, 0, 8'h60, 3'd3, 0);
        step("call70",   1, CALL, 8'h70, 1, 0, 8'h70, 3'd4, 0);
        step("call_ovf", 1, CALL, 8'h80, 1, 0, 8'h70, 3'd4, 1);
        step("clr_ovf",  1, HOLD, 8'h00, 1, 1, 8'h70, 3'd4, 0);
        step("ret1",     1, RET,  8'h00, 1, 0, 8'h61, 3'd3, 0);
        step("ret2",     1, RET,  8'h00, 1, 0, 8'h51, 3'd2, 0);
        step("ret3",     1, RET,  8'h00, 1, 0, 8'h41, 3'd1, 0);
        step("ret4",     1, RET,  8'h00, 1, 0, 8'h21, 3'd0, 0);

        step("ret_unf",  1, RET,  8'h00, 1, 0, 8'h21, 3'd0, 1);
        step("clr",      1, HOLD, 8'h00, 1, 1, 8'h21, 3'd0, 0);
        step("ret_clr",  1, RET,  8'h00, 1, 1, 8'h21, 3'd0, 1);
        step("clr2",     1, HOLD, 8'h00, 1, 1, 8'h21, 3'd0, 0);
        step("reserved", 1, RSV,  8'h99, 1, 0, 8'h21, 3'd0, 0);

        step("call30",   1, CALL, 8'h30, 1, 0, 8'h30, 3'd1, 0);
        for (int i = 0; i < 8; i++) begin
            step($sformatf("idle_op%0d", i), 0, 3'(i), 8'h55, 1, 0, 8'h30, 3'd1, 0);
        end

        step("call40b",  1, CALL, 8'h40, 1, 0, 8'h40, 3'd2, 0);
        // Reset lands between edges while a further CALL is being presented
        @(negedge clk);
        #1;
        en    = 1'b1;
        op    = CALL;
        din   = 8'h50;
        rd_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        expect_state("mid_rst", 8'h00, 3'd0, 1'b0);
        step("rst_ret",  1, RET,  8'h00, 1, 0, 8'h00, 3'd0, 1);
        step("sticky",   1, LOAD, 8'h0A, 1, 0, 8'h0A, 3'd0, 1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
